// File: rtl/clock_set_ctrl.sv
// Alarm-clock control FSM: time setting, alarm setting, one-second prescaler
// and alarm detection for an external packed-BCD 12-hour timer.
module clock_set_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_alm,
  input  logic       btn_inc,
  input  logic       alarm_arm,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  input  logic       cur_pm,
  output logic       tick_ena,
  output logic       load,
  output logic [7:0] ld_hh,
  output logic [7:0] ld_mm,
  output logic [7:0] ld_ss,
  output logic       ld_pm,
  output logic       alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_HH = 3'd1,
    SET_MM = 3'd2,
    AL_HH  = 3'd3,
    AL_MM  = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] presc_q;
  logic [7:0]  edit_hh;
  logic [7:0]  edit_mm;
  logic        edit_pm;
  logic [7:0]  al_hh;
  logic [7:0]  al_mm;
  logic        al_pm;
  logic        fired_q;

  logic        btn_any;
  logic        consume;
  logic        capture;
  logic        do_load;
  logic        inc_edit_hh;
  logic        inc_edit_mm;
  logic        inc_al_hh;
  logic        inc_al_mm;
  logic        match_raw;
  logic        alarm_set;

  // 12-hour BCD hour step; returns {pm, hh}. pm flips only on 11 -> 12.
  function automatic logic [8:0] hour_next(input logic [7:0] hh, input logic pm);
    logic [8:0] r;
    case (hh)
      8'h01, 8'h02, 8'h03, 8'h04,
      8'h05, 8'h06, 8'h07, 8'h08: r = {pm, hh + 8'h01};
      8'h09:                      r = {pm, 8'h10};
      8'h10:                      r = {pm, 8'h11};
      8'h11:                      r = {~pm, 8'h12};
      default:                    r = {pm, 8'h01};
    endcase
    return r;
  endfunction

  // BCD minute step 00..59, wrapping without carry into the hour.
  function automatic logic [7:0] min_next(input logic [7:0] mm);
    logic [7:0] r;
    if (mm >= 8'h59)
      r = 8'h00;
    else if (mm[3:0] >= 4'h9)
      r = {mm[7:4] + 4'h1, 4'h0};
    else
      r = mm + 8'h01;
    return r;
  endfunction

  assign state   = state_q;
  assign btn_any = btn_mode | btn_alm | btn_inc;
  // A button press while ringing only silences the alarm.
  assign consume = alarm & btn_any;

  assign match_raw = (state_q == RUN) && alarm_arm &&
                     (cur_hh == al_hh) && (cur_mm == al_mm) &&
                     (cur_pm == al_pm) && (cur_ss == 8'h00);
  assign alarm_set = match_raw && !tick_ena && !fired_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next-state decode and per-state edit actions; a step button wins over btn_inc.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    do_load     = 1'b0;
    inc_edit_hh = 1'b0;
    inc_edit_mm = 1'b0;
    inc_al_hh   = 1'b0;
    inc_al_mm   = 1'b0;
    if (!consume) begin
      case (state_q)
        RUN: begin
          if (btn_mode) begin
            state_d = SET_HH;
            capture = 1'b1;
          end else if (btn_alm) begin
            state_d = AL_HH;
          end
        end
        SET_HH: begin
          if (btn_mode)     state_d = SET_MM;
          else if (btn_inc) inc_edit_hh = 1'b1;
        end
        SET_MM: begin
          if (btn_mode) begin
            state_d = RUN;
            do_load = 1'b1;
          end else if (btn_inc) begin
            inc_edit_mm = 1'b1;
          end
        end
        AL_HH: begin
          if (btn_alm)      state_d = AL_MM;
          else if (btn_inc) inc_al_hh = 1'b1;
        end
        AL_MM: begin
          if (btn_alm)      state_d = RUN;
          else if (btn_inc) inc_al_mm = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Prescaler: counts only while staying in RUN, so entering RUN (or loading) restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      tick_ena <= 1'b0;
    end else if (state_q == RUN && state_d == RUN) begin
      if (presc_q == DIV_LAST) begin
        presc_q  <= '0;
        tick_ena <= 1'b1;
      end else begin
        presc_q  <= presc_q + 16'd1;
        tick_ena <= 1'b0;
      end
    end else begin
      presc_q  <= '0;
      tick_ena <= 1'b0;
    end
  end

  // Load strobe and held load value; seconds always load as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load  <= 1'b0;
      ld_hh <= 8'h12;
      ld_mm <= 8'h00;
      ld_ss <= 8'h00;
      ld_pm <= 1'b0;
    end else begin
      load <= do_load;
      if (do_load) begin
        ld_hh <= edit_hh;
        ld_mm <= edit_mm;
        ld_ss <= 8'h00;
        ld_pm <= edit_pm;
      end
    end
  end

  // Time edit registers: snapshot the running time, then step in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edit_hh <= 8'h12;
      edit_mm <= 8'h00;
      edit_pm <= 1'b0;
    end else if (capture) begin
      edit_hh <= cur_hh;
      edit_mm <= cur_mm;
      edit_pm <= cur_pm;
    end else if (inc_edit_hh) begin
      {edit_pm, edit_hh} <= hour_next(edit_hh, edit_pm);
    end else if (inc_edit_mm) begin
      edit_mm <= min_next(edit_mm);
    end
  end

  // Alarm time registers, edited directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      al_hh <= 8'h12;
      al_mm <= 8'h00;
      al_pm <= 1'b0;
    end else if (inc_al_hh) begin
      {al_pm, al_hh} <= hour_next(al_hh, al_pm);
    end else if (inc_al_mm) begin
      al_mm <= min_next(al_mm);
    end
  end

  // Alarm ring: fires once per match window; any button or disarm silences it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm   <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      fired_q <= match_raw & (fired_q | alarm_set);
      if (btn_any || !alarm_arm) alarm <= 1'b0;
      else if (alarm_set)        alarm <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: expected load values are queued when the
// committing button is driven and popped whenever the DUT strobes load.
module tb_clock_set_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_alm;
  logic       btn_inc;
  logic       alarm_arm;
  logic [7:0] cur_hh;
  logic [7:0] cur_mm;
  logic [7:0] cur_ss;
  logic       cur_pm;
  logic       tick_ena;
  logic       load;
  logic [7:0] ld_hh;
  logic [7:0] ld_mm;
  logic [7:0] ld_ss;
  logic       ld_pm;
  logic       alarm;
  logic [2:0] state;

  typedef logic [24:0] ld_t;
  ld_t exp_q[$];
  int  total;
  int  bad;

  clock_set_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_alm(btn_alm), .btn_inc(btn_inc),
    .alarm_arm(alarm_arm),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss), .cur_pm(cur_pm),
    .tick_ena(tick_ena), .load(load),
    .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
    .alarm(alarm), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; at the falling edge any load strobe is checked against the scoreboard.
  task automatic cyc();
    ld_t e;
    @(negedge clk);
    if (load === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL load_unexpected: load=%b ld=%h:%h:%h pm=%b, no load expected",
                 load, ld_hh, ld_mm, ld_ss, ld_pm);
      end else begin
        e = exp_q.pop_front();
        if ({ld_hh, ld_mm, ld_ss, ld_pm} !== e) begin
          bad++;
          $display("FAIL load_value: got %h:%h:%h pm=%b, want %h:%h:%h pm=%b",
                   ld_hh, ld_mm, ld_ss, ld_pm, e[24:17], e[16:9], e[8:1], e[0]);
        end
      end
    end
  endtask

  task automatic press(input logic m, input logic a, input logic i);
    btn_mode = m;
    btn_alm  = a;
    btn_inc  = i;
    cyc();
    btn_mode = 1'b0;
    btn_alm  = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic set_cur(input logic [7:0] hh, input logic [7:0] mm,
                         input logic [7:0] ss, input logic pm);
    cur_hh = hh;
    cur_mm = mm;
    cur_ss = ss;
    cur_pm = pm;
  endtask

  task automatic test_reset();
    logic want;
    reset = 1'b0;
    cyc();
    cyc();
    total++;
    if ({state, tick_ena, load, alarm} !== 6'b000000) begin
      bad++;
      $display("FAIL reset_ctrl: state=%0d tick=%b load=%b alarm=%b, want 0 0 0 0",
               state, tick_ena, load, alarm);
    end
    total++;
    if ({ld_hh, ld_mm, ld_ss, ld_pm} !== {8'h12, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_ld: got %h:%h:%h pm=%b, want 12:00:00 pm=0",
               ld_hh, ld_mm, ld_ss, ld_pm);
    end
    reset = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      want = (n % 4 == 0);
      total++;
      if (tick_ena !== want) begin
        bad++;
        $display("FAIL tick_cycle_%0d: tick_ena=%b, want %b", n, tick_ena, want);
      end
    end
  endtask

  task automatic test_set_time();
    logic want;
    set_cur(8'h11, 8'h58, 8'h30, 1'b0);
    press(1, 0, 0);
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL set_enter_hh: state=%0d, want 1", state);
    end
    press(0, 0, 1);
    press(1, 0, 0);
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL set_enter_mm: state=%0d, want 2", state);
    end
    press(0, 0, 1);
    press(0, 0, 1);
    for (int n = 0; n < 5; n++) begin
      cyc();
      total++;
      if (tick_ena !== 1'b0 || state !== 3'd2) begin
        bad++;
        $display("FAIL set_idle_no_tick: tick_ena=%b state=%0d, want 0 2", tick_ena, state);
      end
    end
    exp_q.push_back({8'h12, 8'h00, 8'h00, 1'b1});
    press(1, 0, 0);
    total++;
    if (state !== 3'd0 || load !== 1'b1) begin
      bad++;
      $display("FAIL set_commit: state=%0d load=%b, want 0 1", state, load);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      want = (k == 4);
      total++;
      if (tick_ena !== want) begin
        bad++;
        $display("FAIL tick_after_load_%0d: tick_ena=%b, want %b", k, tick_ena, want);
      end
      if (k == 1) begin
        total++;
        if (load !== 1'b0 || {ld_hh, ld_mm, ld_ss, ld_pm} !== {8'h12, 8'h00, 8'h00, 1'b1}) begin
          bad++;
          $display("FAIL load_hold: load=%b ld=%h:%h:%h pm=%b, want 0 12:00:00 pm=1",
                   load, ld_hh, ld_mm, ld_ss, ld_pm);
        end
      end
    end
  endtask

  task automatic test_hour_wrap();
    set_cur(8'h12, 8'h59, 8'h10, 1'b1);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 0, 1);
    exp_q.push_back({8'h01, 8'h00, 8'h00, 1'b1});
    press(1, 0, 0);
    set_cur(8'h09, 8'h09, 8'h00, 1'b0);
    press(1, 0, 0);
    press(0, 0, 1);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 0, 1);
    exp_q.push_back({8'h11, 8'h10, 8'h00, 1'b0});
    press(1, 0, 0);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL wrap_back_run: state=%0d, want 0", state);
    end
  endtask

  task automatic test_simultaneous();
    set_cur(8'h03, 8'h15, 8'h20, 1'b0);
    press(1, 0, 0);
    press(1, 0, 1);
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL simul_mode_inc: state=%0d, want 2", state);
    end
    press(0, 1, 0);
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL alm_ignored_in_set: state=%0d, want 2", state);
    end
    exp_q.push_back({8'h03, 8'h15, 8'h00, 1'b0});
    press(1, 0, 1);
  endtask

  task automatic test_priority();
    set_cur(8'h05, 8'h45, 8'h00, 1'b1);
    press(1, 1, 0);
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL mode_over_alm: state=%0d, want 1", state);
    end
    press(0, 1, 0);
    press(1, 0, 0);
    exp_q.push_back({8'h05, 8'h45, 8'h00, 1'b1});
    press(1, 0, 0);
    press(0, 0, 1);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL inc_ignored_in_run: state=%0d, want 0", state);
    end
  endtask

  task automatic test_alarm();
    alarm_arm = 1'b0;
    set_cur(8'h07, 8'h30, 8'h01, 1'b1);
    press(0, 1, 0);
    press(1, 0, 0);
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL al_hh_mode_ignored: state=%0d, want 3", state);
    end
    for (int n = 0; n < 19; n++) press(0, 0, 1);
    press(0, 1, 0);
    total++;
    if (state !== 3'd4) begin
      bad++;
      $display("FAIL al_enter_mm: state=%0d, want 4", state);
    end
    for (int n = 0; n < 30; n++) press(0, 0, 1);
    press(0, 1, 0);
    total++;
    if (state !== 3'd0 || load !== 1'b0) begin
      bad++;
      $display("FAIL al_exit: state=%0d load=%b, want 0 0", state, load);
    end
    alarm_arm = 1'b1;
    set_cur(8'h07, 8'h30, 8'h00, 1'b0);
    for (int n = 0; n < 3; n++) begin
      cyc();
      total++;
      if (alarm !== 1'b0) begin
        bad++;
        $display("FAIL alarm_pm_mismatch: alarm=%b, want 0", alarm);
      end
    end
    set_cur(8'h07, 8'h30, 8'h01, 1'b1);
    for (int n = 0; n < 3; n++) begin
      cyc();
      total++;
      if (alarm !== 1'b0) begin
        bad++;
        $display("FAIL alarm_ss_nonzero: alarm=%b, want 0", alarm);
      end
    end
    cur_ss = 8'h00;
    cyc();
    cyc();
    total++;
    if (alarm !== 1'b1) begin
      bad++;
      $display("FAIL alarm_ring: alarm=%b, want 1", alarm);
    end
    press(0, 0, 1);
    total++;
    if (alarm !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL alarm_clear_inc: alarm=%b state=%0d, want 0 0", alarm, state);
    end
    for (int n = 0; n < 3; n++) begin
      cyc();
      total++;
      if (alarm !== 1'b0) begin
        bad++;
        $display("FAIL alarm_one_shot: alarm=%b, want 0", alarm);
      end
    end
    cur_ss = 8'h01;
    cyc();
    cur_ss = 8'h00;
    cyc();
    cyc();
    total++;
    if (alarm !== 1'b1) begin
      bad++;
      $display("FAIL alarm_rering: alarm=%b, want 1", alarm);
    end
    press(1, 0, 0);
    total++;
    if (alarm !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL alarm_clear_mode_no_step: alarm=%b state=%0d, want 0 0", alarm, state);
    end
    cur_ss = 8'h01;
    cyc();
    cur_ss = 8'h00;
    cyc();
    cyc();
    alarm_arm = 1'b0;
    cyc();
    total++;
    if (alarm !== 1'b0) begin
      bad++;
      $display("FAIL alarm_disarm: alarm=%b, want 0", alarm);
    end
  endtask

  task automatic test_reset_mid_edit();
    logic want;
    set_cur(8'h02, 8'h22, 8'h00, 1'b0);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    reset = 1'b0;
    #1;
    total++;
    if ({state, load, alarm} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_mid_edit: state=%0d load=%b alarm=%b, want 0 0 0", state, load, alarm);
    end
    total++;
    if ({ld_hh, ld_mm, ld_ss, ld_pm} !== {8'h12, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_ld: got %h:%h:%h pm=%b, want 12:00:00 pm=0",
               ld_hh, ld_mm, ld_ss, ld_pm);
    end
    for (int n = 0; n < 3; n++) cyc();
    total++;
    if (tick_ena !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold_tick: tick_ena=%b, want 0", tick_ena);
    end
    reset = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      want = (n % 4 == 0);
      total++;
      if (tick_ena !== want) begin
        bad++;
        $display("FAIL tick_after_reset_%0d: tick_ena=%b, want %b", n, tick_ena, want);
      end
    end
    alarm_arm = 1'b1;
    set_cur(8'h12, 8'h00, 8'h00, 1'b0);
    cyc();
    cyc();
    total++;
    if (alarm !== 1'b1) begin
      bad++;
      $display("FAIL alarm_reg_reset_1200am: alarm=%b, want 1", alarm);
    end
    alarm_arm = 1'b0;
    cyc();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    btn_mode  = 1'b0;
    btn_alm   = 1'b0;
    btn_inc   = 1'b0;
    alarm_arm = 1'b0;
    set_cur(8'h12, 8'h00, 8'h05, 1'b0);
    test_reset();
    test_set_time();
    test_hour_wrap();
    test_simultaneous();
    test_priority();
    test_alarm();
    test_reset_mid_edit();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL load_missing: %0d expected loads never seen, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning clk cycles per one-second tick_ena pulse (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port btn_mode, input, 1 bit: debounced single-cycle pulse that steps the set-time sequence.
REQ-005 SHALL have port btn_alm, input, 1 bit: debounced single-cycle pulse that steps the alarm-set sequence.
REQ-006 SHALL have port btn_inc, input, 1 bit: debounced single-cycle pulse that increments the field being edited.
REQ-007 SHALL have port alarm_arm, input, 1 bit: level; 1 = alarm enabled.
REQ-008 SHALL have ports cur_hh/cur_mm/cur_ss, input, 8 bits each, plus cur_pm, input, 1 bit: packed-BCD time from the timer.
REQ-009 SHALL have port tick_ena, output, 1 bit: count enable to the timer.
REQ-010 SHALL have port load, output, 1 bit: one-cycle load strobe to the timer.
REQ-011 SHALL have ports ld_hh/ld_mm/ld_ss, output, 8 bits each, plus ld_pm, output, 1 bit: load value, BCD.
REQ-012 SHALL have port alarm, output, 1 bit: alarm ringing.
REQ-013 SHALL have port state, output, 3 bits: current FSM state code.

Function
REQ-014 SHALL implement states RUN=0, SET_HH=1, SET_MM=2, AL_HH=3, AL_MM=4; no other codes reachable.
REQ-015 In RUN, SHALL pulse tick_ena high for exactly 1 cycle every TICK_DIV cycles; tick_ena SHALL be 0 in all other states.
REQ-016 RUN + btn_mode -> SET_HH next cycle; edit_hh/edit_pm SHALL capture cur_hh/cur_pm on the same edge, and edit_mm SHALL capture cur_mm.
REQ-017 SET_HH + btn_mode -> SET_MM; SET_MM + btn_mode -> RUN, with load=1 for that one cycle, ld_hh=edit_hh, ld_mm=edit_mm, ld_ss=8'h00, ld_pm=edit_pm.
REQ-018 On the load cycle, the prescaler SHALL clear, so the first tick_ena follows the load by TICK_DIV cycles.
REQ-019 RUN + btn_alm -> AL_HH; AL_HH + btn_alm -> AL_MM; AL_MM + btn_alm -> RUN; alarm registers SHALL be edited in place; no load pulse.
REQ-020 Hour increment (SET_HH, AL_HH) SHALL follow 12-hour BCD: 01..09 -> next, 09->10, 10->11, 11->12 with pm toggled, 12->01 with pm unchanged.
REQ-021 Minute increment (SET_MM, AL_MM) SHALL be BCD 00..59; 59->00 with no hour carry.
REQ-022 btn_inc in RUN SHALL be ignored; btn_mode in AL_* and btn_alm in SET_* SHALL be ignored.
REQ-023 Simultaneous step button and btn_inc SHALL apply the state step only; the increment is dropped.
REQ-024 Simultaneous btn_mode and btn_alm in RUN SHALL take btn_mode.
REQ-025 alarm SHALL set when state=RUN, alarm_arm=1, cur_hh=al_hh, cur_mm=al_mm, cur_pm=al_pm, cur_ss=8'h00, and tick_ena=0 (one-shot per match).
REQ-026 alarm SHALL clear on the cycle after any button pulse or when alarm_arm=0; a button that clears alarm SHALL NOT also step the state.
REQ-027 load SHALL be 0 except per REQ-017; ld_* SHALL hold their last values when load=0.

Reset
REQ-028 While reset=0: state=RUN, tick_ena=0, load=0, alarm=0, prescaler=0, ld_hh=8'h12, ld_mm=8'h00, ld_ss=8'h00, ld_pm=0.
REQ-029 While reset=0, edit and alarm registers SHALL be 12:00 AM (hh=8'h12, mm=8'h00, pm=0).
REQ-030 Reset asserted mid-edit SHALL abandon the edit immediately with no load pulse; the first tick_ena follows deassertion by TICK_DIV cycles.

Verification
REQ-031 Release reset, idle 20 cycles with TICK_DIV=4 -> tick_ena high on cycles 4, 8, 12, 16, 20, one cycle each.
REQ-032 cur=11:58 AM; mode, inc, mode, inc x2, mode -> load pulse with ld_hh=8'h12, ld_mm=8'h00, ld_ss=8'h00, ld_pm=1.
REQ-033 In SET_HH, edit=12 PM; inc -> 01 PM; in SET_MM, edit=59; inc -> 00 with hour unchanged.
REQ-034 Alarm set to 07:30 PM, arm=1, cur=07:30:00 PM in RUN -> alarm=1; btn_inc -> alarm=0 next cycle, state stays RUN.
REQ-035 Send btn_mode and btn_inc in the same cycle in SET_HH -> state SET_MM, edit_hh unchanged.
REQ-036 Assert reset in SET_MM -> state=RUN, load never pulses, alarm=0.
